despachante_fila: RTL and testbench
===================================

# despachante_fila

Consumer end of the SmartCargo request queue. Reads the head entry (address 0) of the 16-entry request RAM and decodes it into a target floor and a load/unload operation. It drives the motion controller with a valid/arrival handshake, holds a timed stop at the floor, then retires the entry by pulsing `shift`. The block sits between the request RAM and the motor/door control.

## Interface
Parameters:
- `T_PARADA`, 8: stop (door-open) duration in clock cycles, 1..255.
- `T_TIMEOUT`, 200: maximum cycles in MOVE before error. Used only with `DESPACHANTE_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock, rising edge.
- `clear` input 1: synchronous active-high reset.
- `iniciar` input 1: level enable. While low, no new entry is fetched.
- `andar_atual` input 2: current cargo floor.
- `chegou` input 1: single-cycle pulse from motion controller, arrived at `alvo_andar`.
- `ram_eh_origem` input 1: head entry field from the RAM.
- `ram_tipo_objeto` input 2: head entry field from the RAM.
- `ram_origem_objeto` input 2: head entry field from the RAM.
- `ram_destino_objeto` input 2: head entry field from the RAM.
- `ram_addr` output 4: RAM read address. Constant 0.
- `shift` output 1: single-cycle pop pulse to the RAM.
- `mover` output 1: request to the motion controller. Held high until `chegou`.
- `alvo_andar` output 2: target floor.
- `coletar` output 1: 1 = pick up (origin entry), 0 = deliver.
- `tipo_atual` output 2: object type of the entry in service.
- `porta_aberta` output 1: high during the stop.
- `ocupado` output 1: high in every state except IDLE.
- `estado_db` output 3: state code for debug/7-segment display.
- `erro` output 1: timeout flag. Tied 0 without the macro.

## Operation
- Entry = {eh_origem, tipo[1:0], origem[1:0], destino[1:0]}, 7 bits. All-zero means empty; the writer never stores zero.
- States and codes: IDLE=0, LE=1, AVALIA=2, MOVE=3, PARADA=4, POP=5, ERRO=6.
- IDLE: go to LE when `iniciar`=1.
- LE: one settle cycle so the RAM's registered address and any preceding shift have taken effect.
- AVALIA:
  - `iniciar`=0 → IDLE.
  - Entry all-zero → LE (poll).
  - Otherwise latch the entry. `alvo_andar` = origem if eh_origem, else destino. `coletar` = eh_origem. `tipo_atual` = tipo.
  - If `alvo_andar`==`andar_atual`, go directly to PARADA; else go to MOVE.
- MOVE: `mover`=1. On `chegou` → PARADA.
- PARADA: `porta_aberta`=1 for exactly `T_PARADA` cycles, then → POP.
- POP: `shift`=1 for one cycle, then LE. `iniciar`=0 during service does not abort the entry; it is checked only in AVALIA.
- `chegou` outside MOVE is ignored.
- RAM changes during MOVE/PARADA are ignored; fields are latched.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. `ram_addr` is always 0.
- Minimum service latency, entry present and already at the floor:
  - IDLE→LE→AVALIA→PARADA(T_PARADA)→POP.
  - `shift` asserts T_PARADA+3 cycles after `iniciar` rises.
- `mover` rises the cycle after AVALIA and falls the cycle after `chegou` is sampled.
- `shift` is never high on two consecutive cycles. At least LE+AVALIA (2 cycles) separate pops.
- `clear` mid-operation: next edge forces IDLE, deasserts `mover`/`shift`/`porta_aberta`, clears `erro`. No pop is issued for the interrupted entry.
- Stop counter is 8 bits, counts up from 0, terminal value T_PARADA-1.

## Configuration
- `DESPACHANTE_TIMEOUT_EN` defined:
  - 8-bit-plus counter (width from `T_TIMEOUT`) runs in MOVE.
  - Reaching `T_TIMEOUT` without `chegou` → ERRO: `erro`=1, `mover`=0, no pop.
  - ERRO is left only by `clear`.
- Undefined: no counter, no ERRO state, `erro` tied 0. MOVE waits indefinitely.

## Structure
- Shared package `smartcargo_pkg`:
  - state encoding constants.
  - entry field widths and bit positions (EH_ORIGEM_BIT=6, TIPO=5:4, ORIGEM=3:2, DESTINO=1:0).
  - `ENTRADA_VAZIA`=7'b0.
- One sub-module `contador_parada`: load/enable counter with terminal-count output. Instantiated for the stop timer and, under the macro, for the timeout.

## Test plan
- Empty RAM, `iniciar`=1 → state cycles LE/AVALIA; `shift`, `mover` stay 0 for 50 cycles.
- Head {1,2'b01,2'b10,2'b11}, `andar_atual`=0 → `alvo_andar`=2, `coletar`=1, `mover`=1 until `chegou`. Then `porta_aberta` for 8 cycles, then one `shift` pulse.
- Head {0,2'b10,2'b00,2'b01}, `andar_atual`=1 → no `mover`. `shift` exactly T_PARADA+3 cycles after `iniciar`.
- Two queued entries → two pops, separated by ≥2 idle cycles. Second target taken from the post-shift head.
- `clear` asserted in PARADA → IDLE next cycle, all outputs 0, no `shift`.
- With `DESPACHANTE_TIMEOUT_EN`, `T_TIMEOUT`=20, no `chegou` → `erro`=1 after 20 MOVE cycles, `mover`=0. `clear` recovers.

Source files
------------

// File: rtl/smartcargo_pkg.sv
// Shared SmartCargo definitions: request-entry layout, state codes, decode helper.
package smartcargo_pkg;

  localparam int unsigned ENTRADA_W     = 7;
  localparam int unsigned ANDAR_W       = 2;
  localparam int unsigned TIPO_W        = 2;
  localparam int unsigned ESTADO_W      = 3;
  localparam int unsigned RAM_ADDR_W    = 4;
  localparam int unsigned PARADA_W      = 8;

  localparam int unsigned EH_ORIGEM_BIT = 6;
  localparam int unsigned TIPO_MSB      = 5;
  localparam int unsigned TIPO_LSB      = 4;
  localparam int unsigned ORIGEM_MSB    = 3;
  localparam int unsigned ORIGEM_LSB    = 2;
  localparam int unsigned DESTINO_MSB   = 1;
  localparam int unsigned DESTINO_LSB   = 0;

  localparam logic [ENTRADA_W-1:0] ENTRADA_VAZIA = 7'b0;

  typedef enum logic [ESTADO_W-1:0] {
    IDLE   = 3'd0,
    LE     = 3'd1,
    AVALIA = 3'd2,
    MOVE   = 3'd3,
    PARADA = 3'd4,
    POP    = 3'd5,
    ERRO   = 3'd6
  } estado_t;

  typedef struct packed {
    logic               eh_origem;
    logic [TIPO_W-1:0]  tipo;
    logic [ANDAR_W-1:0] origem;
    logic [ANDAR_W-1:0] destino;
  } entrada_t;

  // Origin entries send the cargo to the pick-up floor, others to the drop floor.
  function automatic logic [ANDAR_W-1:0] alvo_de(input entrada_t e);
    return e.eh_origem ? e.origem : e.destino;
  endfunction

endpackage

// File: rtl/contador_parada.sv
// Up counter with synchronous load-to-zero, enable and terminal-count flag.
module contador_parada #(
  parameter int unsigned LARGURA = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               carregar_i,
  input  logic               habilitar_i,
  input  logic [LARGURA-1:0] limite_i,
  output logic               fim_c
);

  logic [LARGURA-1:0] cnt_q;

  // Count register: restarts at zero on load, saturates at the limit.
  always_ff @(posedge clk) begin
    if (clear || carregar_i) begin
      cnt_q <= '0;
    end else if (habilitar_i && !fim_c) begin
      cnt_q <= cnt_q + LARGURA'(1);
    end
  end

  assign fim_c = (cnt_q == limite_i);

endmodule

// File: rtl/despachante_fila.sv
// Request-queue dispatcher: fetches the RAM head entry, drives the cargo to the
// target floor, holds a timed door stop and pops the entry.
// Optional MOVE watchdog enabled by defining DESPACHANTE_TIMEOUT_EN.
module despachante_fila
  import smartcargo_pkg::*;
#(
  parameter int unsigned T_PARADA  = 8,
  parameter int unsigned T_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       iniciar,
  input  logic [1:0] andar_atual,
  input  logic       chegou,
  input  logic       ram_eh_origem,
  input  logic [1:0] ram_tipo_objeto,
  input  logic [1:0] ram_origem_objeto,
  input  logic [1:0] ram_destino_objeto,
  output logic [3:0] ram_addr,
  output logic       shift,
  output logic       mover,
  output logic [1:0] alvo_andar,
  output logic       coletar,
  output logic [1:0] tipo_atual,
  output logic       porta_aberta,
  output logic       ocupado,
  output logic [2:0] estado_db,
  output logic       erro
);

  estado_t            state_q, state_d;
  logic [ANDAR_W-1:0] alvo_q, alvo_d;
  logic               coletar_q, coletar_d;
  logic [TIPO_W-1:0]  tipo_q, tipo_d;
  logic               mover_q, shift_q, porta_q, ocupado_q;
  logic [ENTRADA_W-1:0] entrada_c;
  entrada_t           ent_c;
  logic               parada_fim_c;

  // Assemble the head entry from the individual RAM fields.
  always_comb begin
    entrada_c                          = ENTRADA_VAZIA;
    entrada_c[EH_ORIGEM_BIT]           = ram_eh_origem;
    entrada_c[TIPO_MSB:TIPO_LSB]       = ram_tipo_objeto;
    entrada_c[ORIGEM_MSB:ORIGEM_LSB]   = ram_origem_objeto;
    entrada_c[DESTINO_MSB:DESTINO_LSB] = ram_destino_objeto;
  end

  assign ent_c = entrada_t'(entrada_c);

  contador_parada #(.LARGURA(PARADA_W)) u_parada (
    .clk         (clk),
    .clear       (clear),
    .carregar_i  (state_q != PARADA),
    .habilitar_i (state_q == PARADA),
    .limite_i    (PARADA_W'(T_PARADA - 1)),
    .fim_c       (parada_fim_c)
  );

`ifdef DESPACHANTE_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(T_TIMEOUT + 1) > 8) ? $clog2(T_TIMEOUT + 1) : 8;
  logic to_fim_c;
  logic erro_q;

  contador_parada #(.LARGURA(TO_W)) u_timeout (
    .clk         (clk),
    .clear       (clear),
    .carregar_i  (state_q != MOVE),
    .habilitar_i (state_q == MOVE),
    .limite_i    (TO_W'(T_TIMEOUT - 1)),
    .fim_c       (to_fim_c)
  );
`endif

  // Next-state and entry-latch logic.
  always_comb begin
    state_d   = state_q;
    alvo_d    = alvo_q;
    coletar_d = coletar_q;
    tipo_d    = tipo_q;
    case (state_q)
      IDLE:   if (iniciar) state_d = LE;
      LE:     state_d = AVALIA;
      AVALIA: begin
        if (!iniciar) begin
          state_d = IDLE;
        end else if (entrada_c == ENTRADA_VAZIA) begin
          state_d = LE;
        end else begin
          alvo_d    = alvo_de(ent_c);
          coletar_d = ent_c.eh_origem;
          tipo_d    = ent_c.tipo;
          state_d   = (alvo_de(ent_c) == andar_atual) ? PARADA : MOVE;
        end
      end
      MOVE: begin
        if (chegou) state_d = PARADA;
`ifdef DESPACHANTE_TIMEOUT_EN
        else if (to_fim_c) state_d = ERRO;
`endif
      end
      PARADA: if (parada_fim_c) state_d = POP;
      POP:    state_d = LE;
`ifdef DESPACHANTE_TIMEOUT_EN
      ERRO:   state_d = ERRO;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, latched entry fields and registered outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      alvo_q    <= '0;
      coletar_q <= 1'b0;
      tipo_q    <= '0;
      mover_q   <= 1'b0;
      shift_q   <= 1'b0;
      porta_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alvo_q    <= alvo_d;
      coletar_q <= coletar_d;
      tipo_q    <= tipo_d;
      mover_q   <= (state_d == MOVE);
      shift_q   <= (state_d == POP);
      porta_q   <= (state_d == PARADA);
      ocupado_q <= (state_d != IDLE);
    end
  end

`ifdef DESPACHANTE_TIMEOUT_EN
  // Sticky error flag, released only by clear.
  always_ff @(posedge clk) begin
    if (clear) erro_q <= 1'b0;
    else       erro_q <= (state_d == ERRO);
  end
  assign erro = erro_q;
`else
  assign erro = 1'b0;
`endif

  assign ram_addr     = 4'd0;
  assign shift        = shift_q;
  assign mover        = mover_q;
  assign alvo_andar   = alvo_q;
  assign coletar      = coletar_q;
  assign tipo_atual   = tipo_q;
  assign porta_aberta = porta_q;
  assign ocupado      = ocupado_q;
  assign estado_db    = 3'(state_q);

endmodule

// File: tb/tb_despachante_fila.sv
// Bench for despachante_fila: RAM queue model, motion-controller model and a
// scoreboard of expected {alvo, coletar, tipo} checked at every pop.
module tb_despachante_fila;

  localparam int unsigned TP = 8;
  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       clear, iniciar;
  logic [1:0] andar_atual;
  logic       chegou = 1'b0;
  logic [6:0] head = 7'b0;
  logic [3:0] ram_addr;
  logic       shift, mover, coletar, porta_aberta, ocupado, erro;
  logic [1:0] alvo_andar, tipo_atual;
  logic [2:0] estado_db;

  logic [6:0] fila[$];
  logic [4:0] sb[$];
  int         n_checks = 0;
  int         n_err = 0;
  bit         modelo_on = 1'b1;
  bit         shift_ant = 1'b0;
  int         atraso = 0;

  always #5 clk = ~clk;

  despachante_fila #(.T_PARADA(TP), .T_TIMEOUT(TO)) dut (
    .clk                (clk),
    .clear              (clear),
    .iniciar            (iniciar),
    .andar_atual        (andar_atual),
    .chegou             (chegou),
    .ram_eh_origem      (head[6]),
    .ram_tipo_objeto    (head[5:4]),
    .ram_origem_objeto  (head[3:2]),
    .ram_destino_objeto (head[1:0]),
    .ram_addr           (ram_addr),
    .shift              (shift),
    .mover              (mover),
    .alvo_andar         (alvo_andar),
    .coletar            (coletar),
    .tipo_atual         (tipo_atual),
    .porta_aberta       (porta_aberta),
    .ocupado            (ocupado),
    .estado_db          (estado_db),
    .erro               (erro)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected {alvo, coletar, tipo} decoded independently from a raw entry.
  function automatic logic [4:0] esperado(input logic [6:0] e);
    logic [1:0] alvo;
    alvo = e[6] ? e[3:2] : e[1:0];
    return {alvo, e[6], e[5:4]};
  endfunction

  task automatic enfileira(input logic [6:0] e, input bit espera_pop);
    fila.push_back(e);
    if (espera_pop) sb.push_back(esperado(e));
  endtask

  // RAM pop on shift, scoreboard compare, head refresh and motion-controller model.
  always @(negedge clk) begin
    logic [4:0] e;
    if (shift) begin
      chk("shift_consecutivo", 32'(shift_ant), 0);
      if (sb.size() == 0) chk("pop_inesperado", 1, 0);
      else begin
        e = sb.pop_front();
        chk("pop_campos", 32'({alvo_andar, coletar, tipo_atual}), 32'(e));
      end
      if (fila.size() > 0) void'(fila.pop_front());
    end
    shift_ant = shift;
    head = (fila.size() > 0) ? fila[0] : 7'b0;
    if (chegou) chegou = 1'b0;
    else if (mover && modelo_on) begin
      if (atraso == 4) begin chegou = 1'b1; atraso = 0; end
      else atraso++;
    end else atraso = 0;
  end

  task automatic ate_shift(output int ciclos, output int n_porta, output int n_mover, output bit ok);
    ciclos = 0; n_porta = 0; n_mover = 0; ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      ciclos++;
      if (porta_aberta) n_porta++;
      if (mover) n_mover++;
      if (mover && porta_aberta) chk("mover_e_porta", 1, 0);
      if (shift) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ate_idle(input string tag);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (estado_db == 3'd0) break;
    end
    chk(tag, 32'(estado_db), 0);
  endtask

  task automatic ate_mover(input string tag);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (mover) break;
    end
    chk(tag, 32'(mover), 1);
  endtask

  initial begin
    int  c, np, nm, ns, nbad;
    bit  ok;
    clear = 1'b1; iniciar = 1'b0; andar_atual = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_saidas", 32'({ram_addr, shift, mover, alvo_andar, coletar, tipo_atual,
                              porta_aberta, ocupado, estado_db, erro}), 0);
    clear = 1'b0;

    // Empty RAM: polls LE/AVALIA, never moves or pops.
    iniciar = 1'b1; ns = 0; nm = 0; nbad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (shift) ns++;
      if (mover) nm++;
      if (estado_db != 3'd1 && estado_db != 3'd2) nbad++;
    end
    chk("vazio_shift", ns, 0);
    chk("vazio_mover", nm, 0);
    chk("vazio_estados", nbad, 0);
    chk("vazio_ocupado", 32'(ocupado), 1);
    iniciar = 1'b0;
    ate_idle("vazio_idle");

    // Origin entry needing a move; iniciar dropped mid-service must not abort it.
    andar_atual = 2'd0;
    enfileira(7'b1_01_10_11, 1'b1);
    iniciar = 1'b1;
    ate_mover("t2_mover");
    chk("t2_alvo", 32'(alvo_andar), 2);
    chk("t2_coletar", 32'(coletar), 1);
    chk("t2_tipo", 32'(tipo_atual), 1);
    iniciar = 1'b0;
    ate_shift(c, np, nm, ok);
    chk("t2_shift", 32'(ok), 1);
    chk("t2_porta_ciclos", np, TP);
    ate_idle("t2_idle");

    // Delivery already at the floor: minimum latency, no motion.
    andar_atual = 2'd1;
    enfileira(7'b0_10_00_01, 1'b1);
    iniciar = 1'b1;
    ate_shift(c, np, nm, ok);
    chk("t3_shift", 32'(ok), 1);
    chk("t3_latencia", c, TP + 3);
    chk("t3_sem_mover", nm, 0);
    chk("t3_porta_ciclos", np, TP);
    iniciar = 1'b0;
    ate_idle("t3_idle");

    // Two queued entries: two pops, second target from the post-pop head.
    andar_atual = 2'd1;
    enfileira(7'b0_11_10_10, 1'b1);
    enfileira(7'b1_00_11_00, 1'b1);
    iniciar = 1'b1;
    ate_shift(c, np, nm, ok);
    chk("t4_shift1", 32'(ok), 1);
    ate_shift(c, np, nm, ok);
    chk("t4_shift2", 32'(ok), 1);
    chk("t4_intervalo", 32'(c >= 3), 1);
    chk("t4_alvo2", 32'(alvo_andar), 3);
    iniciar = 1'b0;
    ate_idle("t4_idle");
    chk("t4_fila_vazia", fila.size(), 0);

    // Clear during the stop: everything drops, no pop for that entry.
    andar_atual = 2'd2;
    enfileira(7'b0_00_00_10, 1'b0);
    iniciar = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (porta_aberta) break;
    end
    chk("t5_porta", 32'(porta_aberta), 1);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    chk("t5_clear_saidas", 32'({ram_addr, shift, mover, alvo_andar, coletar, tipo_atual,
                                 porta_aberta, ocupado, estado_db, erro}), 0);
    clear = 1'b0; iniciar = 1'b0; ns = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (shift) ns++;
    end
    chk("t5_sem_pop", ns, 0);
    fila.delete();

`ifdef DESPACHANTE_TIMEOUT_EN
    // No arrival: error after TO cycles in MOVE, cleared only by clear.
    modelo_on = 1'b0;
    andar_atual = 2'd0;
    enfileira(7'b0_00_00_11, 1'b0);
    iniciar = 1'b1;
    ate_mover("to_mover");
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      c++;
      if (erro) break;
    end
    chk("to_ciclos", c, TO);
    chk("to_erro", 32'(erro), 1);
    chk("to_mover_baixo", 32'(mover), 0);
    chk("to_estado", 32'(estado_db), 6);
    clear = 1'b1;
    @(posedge clk); #1;
    chk("to_clear", 32'({erro, estado_db}), 0);
    clear = 1'b0; iniciar = 1'b0;
    fila.delete();
    modelo_on = 1'b1;
`endif

    repeat (3) @(posedge clk);
    chk("sb_pendentes", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
